// File: rtl/ctrl_pipe_sequencer_if.sv
// ID-side decode inputs and EX/MEM/WB control outputs of the pipeline control sequencer.
interface ctrl_pipe_sequencer_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    localparam int unsigned CTRL_W = 14;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [CTRL_W-1:0]     id_ctrl;
    logic                  id_reg_write;
    logic                  ex_branch_taken;
    logic                  hold;

    logic [CTRL_W-1:0]     ex_ctrl;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [1:0]            fwd_rs1_sel;
    logic [1:0]            fwd_rs2_sel;
    logic                  mem_dm_read;
    logic                  mem_dm_write;
    logic                  mem_rd_sel;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_data_sel;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_reg_write;
    logic                  stall_if_id;
    logic                  flush_if_id;
    logic                  pc_redirect;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_ctrl, id_reg_write, ex_branch_taken, hold,
        input  ex_ctrl, ex_rd, ex_rs1, ex_rs2, fwd_rs1_sel, fwd_rs2_sel,
               mem_dm_read, mem_dm_write, mem_rd_sel, mem_rd, wb_data_sel,
               wb_rd, wb_reg_write, stall_if_id, flush_if_id, pc_redirect
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_ctrl, id_reg_write, ex_branch_taken, hold,
        output ex_ctrl, ex_rd, ex_rs1, ex_rs2, fwd_rs1_sel, fwd_rs2_sel,
               mem_dm_read, mem_dm_write, mem_rd_sel, mem_rd, wb_data_sel,
               wb_rd, wb_reg_write, stall_if_id, flush_if_id, pc_redirect
    );
endinterface

// File: rtl/ctrl_pipe_sequencer.sv
// Carries decoded control through EX/MEM/WB, resolving redirects, load-use stalls and forwarding.
module ctrl_pipe_sequencer #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter logic [2:0]  BUBBLE_ALUOP = 3'b010
) (
    input logic                 clk,
    input logic                 rst_n,
    ctrl_pipe_sequencer_if.slave bus
);
    localparam int unsigned CTRL_W     = 14;
    localparam int unsigned BR_LO      = 4;
    localparam int unsigned MEM_RD_BIT = 3;
    localparam int unsigned DM_RD_BIT  = 2;
    localparam int unsigned DM_WR_BIT  = 1;
    localparam int unsigned WB_SEL_BIT = 0;
    localparam logic [1:0]  BR_JAL     = 2'b01;
    localparam logic [1:0]  BR_B       = 2'b10;
    localparam logic [1:0]  BR_J       = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [CTRL_W-1:0]     ctrl;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  rd_sel;
        logic                  dm_read;
        logic                  dm_write;
        logic                  wb_sel;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  wb_sel;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } wb_stage_t;

    localparam ex_stage_t EX_BUBBLE = '{
        valid: 1'b0, ctrl: {BUBBLE_ALUOP, 11'b0}, reg_write: 1'b0,
        rd: '0, rs1: '0, rs2: '0
    };

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;

    logic [1:0] ex_branch;
    logic       redirect_req;
    logic       redirect;
    logic       load_use;
    logic       mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
    logic       mem_fwd_ok, wb_fwd_ok;

    // Hazard detection against the instruction currently in EX
    assign ex_branch    = ex_q.ctrl[BR_LO +: 2];
    assign redirect_req = ex_q.valid & ((ex_branch == BR_JAL) | (ex_branch == BR_J) |
                                        ((ex_branch == BR_B) & bus.ex_branch_taken));
    assign redirect     = redirect_req & ~bus.hold;
    assign load_use     = ex_q.valid & ex_q.ctrl[DM_RD_BIT] & (ex_q.rd != '0) & bus.id_valid &
                          ((bus.id_use_rs1 & (bus.id_rs1 == ex_q.rd)) |
                           (bus.id_use_rs2 & (bus.id_rs2 == ex_q.rd)));

    // A load still in MEM has no data yet, so it is excluded as a source
    assign mem_fwd_ok  = mem_q.valid & mem_q.reg_write & ~mem_q.dm_read & (mem_q.rd != '0);
    assign wb_fwd_ok   = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
    assign mem_hit_rs1 = mem_fwd_ok & (mem_q.rd == ex_q.rs1);
    assign mem_hit_rs2 = mem_fwd_ok & (mem_q.rd == ex_q.rs2);
    assign wb_hit_rs1  = wb_fwd_ok & (wb_q.rd == ex_q.rs1);
    assign wb_hit_rs2  = wb_fwd_ok & (wb_q.rd == ex_q.rs2);

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!bus.hold) begin
            wb_d = '{valid: mem_q.valid, wb_sel: mem_q.wb_sel,
                     reg_write: mem_q.reg_write, rd: mem_q.rd};
            mem_d = '{valid:     ex_q.valid,
                      rd_sel:    ex_q.ctrl[MEM_RD_BIT],
                      dm_read:   ex_q.ctrl[DM_RD_BIT],
                      dm_write:  ex_q.ctrl[DM_WR_BIT],
                      wb_sel:    ex_q.ctrl[WB_SEL_BIT],
                      reg_write: ex_q.reg_write,
                      rd:        ex_q.rd};
            if (redirect || load_use || !bus.id_valid) begin
                ex_d = EX_BUBBLE;
            end else begin
                ex_d = '{valid: 1'b1, ctrl: bus.id_ctrl, reg_write: bus.id_reg_write,
                         rd: bus.id_rd, rs1: bus.id_rs1, rs2: bus.id_rs2};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.fwd_rs1_sel  = mem_hit_rs1 ? 2'b01 : (wb_hit_rs1 ? 2'b10 : 2'b00);
    assign bus.fwd_rs2_sel  = mem_hit_rs2 ? 2'b01 : (wb_hit_rs2 ? 2'b10 : 2'b00);
    assign bus.mem_dm_read  = mem_q.valid & mem_q.dm_read;
    assign bus.mem_dm_write = mem_q.valid & mem_q.dm_write;
    assign bus.mem_rd_sel   = mem_q.rd_sel;
    assign bus.mem_rd       = mem_q.rd;
    assign bus.wb_data_sel  = wb_q.wb_sel;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_reg_write = wb_fwd_ok;
    assign bus.pc_redirect  = redirect;
    assign bus.flush_if_id  = redirect;
    assign bus.stall_if_id  = bus.hold | (load_use & ~redirect_req);
endmodule

// File: tb/tb_ctrl_pipe_sequencer.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic against an instruction-level model.
module tb_ctrl_pipe_sequencer;
    localparam logic [13:0] BUBBLE = 14'h1000;

    typedef struct {
        logic        v;
        logic [13:0] c;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
    } instr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    instr_t pipe [3];

    ctrl_pipe_sequencer_if bus ();

    ctrl_pipe_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] mk_ctrl(input logic [1:0] br, input logic ld,
                                            input logic st, input logic wbs);
        return {3'b000, 3'b000, 1'b0, 1'b0, br, ld, ld, st, wbs};
    endfunction

    // Reference forwarding choice: newest completed producer of a nonzero register wins
    function automatic logic [1:0] fwd_model(input instr_t m, input instr_t w, input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (m.v && m.rw && !m.c[2] && m.rd == rs) return 2'b01;
        if (w.v && w.rw && w.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic [13:0] c, input logic rw);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        bus.id_ctrl      = c;
        bus.id_reg_write = rw;
    endtask

    task automatic idle();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 14'd0, 1'b0);
    endtask

    task automatic flush_pipe();
        idle();
        bus.hold = 1'b0;
        bus.ex_branch_taken = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [40:0] got;
        #1;
        got = {bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.fwd_rs1_sel, bus.fwd_rs2_sel,
               bus.mem_dm_read, bus.mem_dm_write, bus.mem_rd_sel, bus.mem_rd,
               bus.wb_data_sel, bus.wb_rd, bus.wb_reg_write,
               bus.stall_if_id, bus.flush_if_id, bus.pc_redirect};
        checks++;
        if (got !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", got);
        end
        checks++;
        if (bus.ex_ctrl !== BUBBLE) begin
            errors++;
            $display("FAIL reset_ex_ctrl got %h want %h", bus.ex_ctrl, BUBBLE);
        end
    endtask

    task automatic test_reset_midrun();
        flush_pipe();
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, mk_ctrl(2'b00, 1'b0, 1'b0, 1'b0), 1'b1);
        tick();
        drive_id(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b0, mk_ctrl(2'b00, 1'b1, 1'b0, 1'b1), 1'b1);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, mk_ctrl(2'b01, 1'b0, 1'b0, 1'b0), 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        #1;
        checks++;
        if ({bus.wb_reg_write, bus.mem_dm_read, bus.pc_redirect, bus.flush_if_id} !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_reset_valids got %b want 0000",
                     {bus.wb_reg_write, bus.mem_dm_read, bus.pc_redirect, bus.flush_if_id});
        end
        checks++;
        if (bus.ex_ctrl !== BUBBLE || bus.ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL midrun_reset_ex got %h/%0d want %h/0", bus.ex_ctrl, bus.ex_rd, BUBBLE);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        flush_pipe();
        drive_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, mk_ctrl(2'b00, 1'b1, 1'b0, 1'b1), 1'b1);
        tick();
        drive_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b1, mk_ctrl(2'b00, 1'b0, 1'b0, 1'b0), 1'b1);
        #1;
        checks++;
        if (bus.stall_if_id !== 1'b1 || bus.pc_redirect !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall got stall=%b redir=%b want 1/0", bus.stall_if_id, bus.pc_redirect);
        end
        tick();
        #1;
        checks++;
        if (bus.ex_ctrl !== BUBBLE || bus.stall_if_id !== 1'b0 || bus.mem_dm_read !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble got ctrl=%h stall=%b dmr=%b want %h/0/1",
                     bus.ex_ctrl, bus.stall_if_id, bus.mem_dm_read, BUBBLE);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.ex_rd !== 5'd6 || bus.fwd_rs1_sel !== 2'b10 || bus.fwd_rs2_sel !== 2'b00 ||
            bus.wb_reg_write !== 1'b1 || bus.wb_rd !== 5'd5) begin
            errors++;
            $display("FAIL lu_forward got rd=%0d f1=%b f2=%b wbw=%b wbrd=%0d want 6/10/00/1/5",
                     bus.ex_rd, bus.fwd_rs1_sel, bus.fwd_rs2_sel, bus.wb_reg_write, bus.wb_rd);
        end
    endtask

    task automatic test_branch();
        flush_pipe();
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, mk_ctrl(2'b10, 1'b0, 1'b0, 1'b0), 1'b0);
        tick();
        idle();
        bus.ex_branch_taken = 1'b1;
        #1;
        checks++;
        if ({bus.pc_redirect, bus.flush_if_id, bus.stall_if_id} !== 3'b110) begin
            errors++;
            $display("FAIL br_taken got %b want 110", {bus.pc_redirect, bus.flush_if_id, bus.stall_if_id});
        end
        tick();
        bus.ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (bus.ex_ctrl !== BUBBLE || bus.pc_redirect !== 1'b0) begin
            errors++;
            $display("FAIL br_after got ctrl=%h redir=%b want %h/0", bus.ex_ctrl, bus.pc_redirect, BUBBLE);
        end
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, mk_ctrl(2'b10, 1'b0, 1'b0, 1'b0), 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if ({bus.pc_redirect, bus.flush_if_id} !== 2'b00) begin
            errors++;
            $display("FAIL br_not_taken got %b want 00", {bus.pc_redirect, bus.flush_if_id});
        end
    endtask

    task automatic test_redirect_load_use();
        flush_pipe();
        // Jump carrying a load strobe so that load-use and redirect coincide
        drive_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, mk_ctrl(2'b01, 1'b1, 1'b0, 1'b0), 1'b1);
        tick();
        drive_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, mk_ctrl(2'b00, 1'b0, 1'b0, 1'b0), 1'b1);
        #1;
        checks++;
        if ({bus.pc_redirect, bus.flush_if_id, bus.stall_if_id} !== 3'b110) begin
            errors++;
            $display("FAIL redir_lu got %b want 110", {bus.pc_redirect, bus.flush_if_id, bus.stall_if_id});
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.ex_ctrl !== BUBBLE || bus.ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL redir_squash got ctrl=%h rd=%0d want %h/0", bus.ex_ctrl, bus.ex_rd, BUBBLE);
        end
    endtask

    task automatic test_hold();
        logic [13:0] jal;
        jal = mk_ctrl(2'b01, 1'b0, 1'b0, 1'b0);
        flush_pipe();
        drive_id(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, jal, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, mk_ctrl(2'b00, 1'b0, 1'b0, 1'b0), 1'b1);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.pc_redirect, bus.stall_if_id, bus.flush_if_id} !== 3'b010 ||
                bus.ex_ctrl !== jal || bus.ex_rd !== 5'd1) begin
                errors++;
                $display("FAIL hold_cycle%0d got rsf=%b ctrl=%h rd=%0d want 010/%h/1", i,
                         {bus.pc_redirect, bus.stall_if_id, bus.flush_if_id}, bus.ex_ctrl, bus.ex_rd, jal);
            end
            tick();
        end
        bus.hold = 1'b0;
        #1;
        checks++;
        if ({bus.pc_redirect, bus.flush_if_id} !== 2'b11) begin
            errors++;
            $display("FAIL hold_release got %b want 11", {bus.pc_redirect, bus.flush_if_id});
        end
        tick();
        idle();
    endtask

    task automatic test_forward();
        logic [13:0] alu;
        alu = mk_ctrl(2'b00, 1'b0, 1'b0, 1'b0);
        flush_pipe();
        drive_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, alu, 1'b1);
        tick();
        drive_id(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 1'b1, alu, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, alu, 1'b1);
        tick();
        idle();
        #1;
        checks++;
        if (bus.fwd_rs2_sel !== 2'b01 || bus.fwd_rs1_sel !== 2'b00) begin
            errors++;
            $display("FAIL fwd_mem_wins got f2=%b f1=%b want 01/00", bus.fwd_rs2_sel, bus.fwd_rs1_sel);
        end
        flush_pipe();
        drive_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, alu, 1'b1);
        tick();
        drive_id(1'b1, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1, alu, 1'b1);
        tick();
        drive_id(1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b1, alu, 1'b1);
        tick();
        idle();
        #1;
        checks++;
        if (bus.fwd_rs2_sel !== 2'b00 || bus.wb_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL fwd_x0 got f2=%b wbw=%b want 00/0", bus.fwd_rs2_sel, bus.wb_reg_write);
        end
    endtask

    task automatic test_random(input int n);
        instr_t      bub;
        logic [1:0]  br;
        logic        redir, lu;
        logic [6:0]  exp_c, got_c;
        logic [46:0] exp_r, got_r;
        bub = '{v: 1'b0, c: BUBBLE, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, rw: 1'b0};
        idle();
        bus.hold = 1'b0;
        bus.ex_branch_taken = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) pipe[k] = bub;
        for (int i = 0; i < n; i++) begin
            bus.id_valid     = ($urandom_range(0, 3) != 0);
            bus.id_rs1       = 5'($urandom_range(0, 3));
            bus.id_rs2       = 5'($urandom_range(0, 3));
            bus.id_rd        = 5'($urandom_range(0, 3));
            bus.id_use_rs1   = 1'($urandom);
            bus.id_use_rs2   = 1'($urandom);
            bus.id_ctrl      = 14'($urandom);
            if ($urandom_range(0, 3) != 0) bus.id_ctrl[5:4] = 2'b00;
            bus.id_reg_write = 1'($urandom);
            bus.ex_branch_taken = 1'($urandom);
            bus.hold         = ($urandom_range(0, 7) == 0);
            #1;
            br    = pipe[0].c[5:4];
            redir = pipe[0].v && (br == 2'b01 || br == 2'b11 || (br == 2'b10 && bus.ex_branch_taken)) &&
                    !bus.hold;
            lu    = pipe[0].v && pipe[0].c[2] && pipe[0].rd != 5'd0 && bus.id_valid &&
                    ((bus.id_use_rs1 && bus.id_rs1 == pipe[0].rd) ||
                     (bus.id_use_rs2 && bus.id_rs2 == pipe[0].rd));
            exp_c = {redir, redir, bus.hold || (lu && !redir),
                     fwd_model(pipe[1], pipe[2], pipe[0].rs1), fwd_model(pipe[1], pipe[2], pipe[0].rs2)};
            got_c = {bus.pc_redirect, bus.flush_if_id, bus.stall_if_id, bus.fwd_rs1_sel, bus.fwd_rs2_sel};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL rand_comb cyc %0d got %b want %b", i, got_c, exp_c);
            end
            exp_r = {pipe[0].c, pipe[0].rd, pipe[0].rs1, pipe[0].rs2,
                     pipe[1].v && pipe[1].c[2], pipe[1].v && pipe[1].c[1], pipe[1].c[3], pipe[1].rd,
                     pipe[2].c[0], pipe[2].rd, pipe[2].v && pipe[2].rw && pipe[2].rd != 5'd0};
            got_r = {bus.ex_ctrl, bus.ex_rd, bus.ex_rs1, bus.ex_rs2,
                     bus.mem_dm_read, bus.mem_dm_write, bus.mem_rd_sel, bus.mem_rd,
                     bus.wb_data_sel, bus.wb_rd, bus.wb_reg_write};
            checks++;
            if (got_r !== exp_r) begin
                errors++;
                $display("FAIL rand_regs cyc %0d got %h want %h", i, got_r, exp_r);
            end
            if (!bus.hold) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                if (redir || lu || !bus.id_valid) pipe[0] = bub;
                else pipe[0] = '{v: 1'b1, c: bus.id_ctrl, rd: bus.id_rd, rs1: bus.id_rs1,
                                 rs2: bus.id_rs2, rw: bus.id_reg_write};
            end
            tick();
        end
    endtask

    initial begin
        clk    = 1'b0;
        rst_n  = 1'b0;
        checks = 0;
        errors = 0;
        idle();
        bus.hold = 1'b0;
        bus.ex_branch_taken = 1'b0;
        tick();
        test_reset();
        rst_n = 1'b1;
        test_reset_midrun();
        test_load_use();
        test_branch();
        test_redirect_load_use();
        test_hold();
        test_forward();
        test_random(2000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
